// File: rtl/y_demux_stream.sv
// y_demux_stream: registered 1-to-LANES stream demultiplexer.
// One valid/ready input stream is steered into one of LANES single-entry
// output registers, each with its own valid/ready handshake. The target lane
// comes from sel (manual) or from an internal round-robin pointer (auto_mode).
// Optional feature macro: Y_DEMUX_PARITY_EN adds a registered even-parity bit
// per lane on out_par; without it out_par is tied to zero.
module y_demux_stream #(
  parameter int WIDTH = 2,
  parameter int LANES = 4,
  parameter int SELW  = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SELW-1:0]        sel,
  input  logic                   auto_mode,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_par,
  output logic [SELW-1:0]        rr_ptr,
  output logic [7:0]             acc_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  lane_state_e      state_q [LANES];
  lane_state_e      state_d [LANES];
  logic [WIDTH-1:0] data_q  [LANES];
  logic [SELW-1:0]  tgt;
  logic             accept;
  logic [LANES-1:0] load;
  logic [LANES-1:0] drain;

  // Target lane selection and the input handshake; in_ready never looks at in_valid.
  always_comb begin
    tgt      = auto_mode ? rr_ptr : sel;
    in_ready = ~out_valid[tgt] | out_ready[tgt];
    accept   = in_valid & in_ready;
  end

  // Per-lane load/drain strobes and the lane FSM next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    load  = '0;
    drain = '0;
    for (int n = 0; n < LANES; n++) begin
      state_d[n] = state_q[n];
      load[n]    = accept && (tgt == SELW'(n));
      drain[n]   = out_valid[n] & out_ready[n];
      case (state_q[n])
        EMPTY: if (load[n]) state_d[n] = FULL;
        FULL:  if (drain[n] && !load[n]) state_d[n] = EMPTY;
        default: state_d[n] = EMPTY;
      endcase
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < LANES; n++) state_q[n] <= EMPTY;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      for (int n = 0; n < LANES; n++) state_q[n] <= state_d[n];
    end
  end

  // Lane data registers; a load replaces the held word, otherwise it is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the lane data array is reset on purpose because out_data must read zero after reset; storage with no such need is left unreset.
      for (int n = 0; n < LANES; n++) data_q[n] <= '0;
    end else begin
      for (int n = 0; n < LANES; n++) begin
        if (load[n]) data_q[n] <= in_data;
      end
    end
  end

`ifdef Y_DEMUX_PARITY_EN
  logic [LANES-1:0] par_q;

  // Parity registered alongside the lane data so both update on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= '0;
    end else begin
      for (int n = 0; n < LANES; n++) begin
        if (load[n]) par_q[n] <= ^in_data;
      end
    end
  end

  // Drive the parity output from its register.
  always_comb out_par = par_q;
`else
  // Parity feature disabled: the output is a constant zero.
  always_comb out_par = '0;
`endif

  // Round-robin pointer: advances only on an accept in auto mode; LANES is a power of two so it wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept && auto_mode) begin
      rr_ptr <= rr_ptr + 1'b1;
    end
  end

  // Accepted-word counter, wrapping modulo 256.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_count <= '0;
    end else if (accept) begin
      acc_count <= acc_count + 8'd1;
    end
  end

  // Flatten lane state and data onto the output ports.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int n = 0; n < LANES; n++) begin
      out_valid[n]               = (state_q[n] == FULL);
      out_data[n*WIDTH +: WIDTH] = data_q[n];
    end
  end

endmodule
